// File: rtl/alu_result_packer_pkg.sv
// alu_result_packer_pkg: word layout constants and the parity helper shared with
// the ALU-side parity checker.
package alu_result_packer_pkg;
    localparam int DATA_W = 15;
    localparam int WORD_W = 16;
    localparam int PARITY_BIT = 0;
    localparam logic [DATA_W-1:0] NEG_ZERO = 15'h7FFF;

    // Odd sense: set p so the 16-bit word carries an odd number of ones.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd_sel);
        return (^data) ^ odd_sel;
    endfunction
endpackage

// File: rtl/alu_result_packer_parity_gen.sv
// parity_gen: parity bit for one 15-bit ones'-complement data field.
module parity_gen
    import alu_result_packer_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              odd_sel,
    output logic              parity
);
    assign parity = calc_parity(data, odd_sel);
endmodule

// File: rtl/alu_result_packer.sv
// alu_result_packer: buffers ALU results as parity-protected 16-bit memory words
// in a small FIFO with valid/ready handshakes on both sides.
module alu_result_packer
    import alu_result_packer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter bit ODD_PARITY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          res_in,
    input  logic                       res_valid,
    output logic                       res_ready,
    output logic [WORD_W-1:0]          word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       neg_zero_seen
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_result_packer: DEPTH must be a power of two in 2..16");
    end

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              neg_zero_seen_q, neg_zero_seen_d;
    logic              push, pop, parity;

    parity_gen u_parity_gen (
        .data    (res_in),
        .odd_sel (ODD_PARITY),
        .parity  (parity)
    );

    assign res_ready     = count_q != CW'(DEPTH);
    assign word_valid    = count_q != '0;
    assign word_out      = mem_q[rd_ptr_q];
    assign count         = count_q;
    assign neg_zero_seen = neg_zero_seen_q;
    assign push          = res_valid && res_ready;
    assign pop           = word_valid && word_ready;

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
    always_comb begin
        wr_ptr_d        = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d        = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d         = count_q + CW'(push) - CW'(pop);
        neg_zero_seen_d = neg_zero_seen_q | (push && res_in == NEG_ZERO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            neg_zero_seen_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            neg_zero_seen_q <= neg_zero_seen_d;
        end
    end

    // Storage holds no reset; reset only blocks the write through push.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem_q[wr_ptr_q] <= {res_in, parity};
    end
endmodule

// File: doc/alu_result_packer.md
ALU_RESULT_PACKER -- requirements
Module: alu_result_packer

Interface
REQ-001: Parameter DEPTH, default 4, SHALL set the number of buffered words; the value SHALL be a power of two, 2..16.
REQ-002: Parameter ODD_PARITY, default 1, SHALL select the parity sense: 1 for odd and 0 for even.
REQ-003: Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004: Port reset, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-005: Port res_in, input, 15 bits, SHALL carry the ones'-complement ALU result.
REQ-006: Port res_valid, input, 1 bit, SHALL indicate that res_in holds a result to accept.
REQ-007: Port res_ready, output, 1 bit, SHALL indicate that the packer can accept a result this cycle.
REQ-008: Port word_out, output, 16 bits, SHALL carry the packed memory word: data in [15:1] and parity in [0].
REQ-009: Port word_valid, output, 1 bit, SHALL indicate that word_out holds the oldest buffered word.
REQ-010: Port word_ready, input, 1 bit, SHALL indicate that the consumer takes word_out this cycle.
REQ-011: Port count, output, $clog2(DEPTH)+1 bits, SHALL give the number of buffered words.
REQ-012: Port neg_zero_seen, output, 1 bit, SHALL be a sticky flag, set when a -0 result (15'h7FFF) is accepted.

Function
REQ-013: A push SHALL occur on any edge where res_valid && res_ready.
REQ-014: A pop SHALL occur on any edge where word_valid && word_ready.
REQ-015: res_ready SHALL equal (count != DEPTH), combinational from registered state only; there is no bypass when full.
REQ-016: word_valid SHALL equal (count != 0).
REQ-017: On a push, the stored word SHALL be {res_in, p}, where p makes the total number of ones in all 16 bits odd (ODD_PARITY=1) or even (ODD_PARITY=0).
REQ-018: Data bits SHALL pass unmodified; -0 SHALL NOT be normalised to +0.
REQ-019: Latency SHALL be one cycle: a word pushed at edge N appears on word_out with word_valid=1 after edge N when the buffer was empty.
REQ-020: Words SHALL leave in push order (FIFO).
REQ-021: word_out SHALL hold stable while word_valid=1 and word_ready=0.
REQ-022: Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and keep both transfers.
REQ-023: Simultaneous push and pop at count=DEPTH SHALL be impossible by REQ-015; only the pop occurs.
REQ-024: At count=0 no pop SHALL occur, and word_out value is don't-care.
REQ-025: Read and write pointers SHALL wrap modulo DEPTH.
REQ-026: neg_zero_seen SHALL set on the edge of a push with res_in=15'h7FFF, and clear only on reset.
REQ-027: A res_valid with res_ready=0 SHALL be ignored; the producer holds res_in until accepted.

Reset
REQ-028: While reset=1 at an edge, count SHALL become 0, both pointers 0, and neg_zero_seen 0, giving word_valid=0 and res_ready=1.
REQ-029: Reset SHALL take priority over a simultaneous push or pop; buffered words SHALL be discarded mid-operation.
REQ-030: Buffer storage contents SHALL NOT need a reset.

Structure
REQ-031: The shared package/include SHALL hold the word-layout constants: DATA_W=15, WORD_W=16, PARITY_BIT=0, NEG_ZERO=15'h7FFF.
REQ-032: The shared package/include SHALL hold a parity function reused by the parity checker on the ALU input side.
REQ-033: The parity generator SHALL be one sub-module, parity_gen (15-bit data plus odd/even select in, 1-bit parity out), instantiated once on the write path.

Verification
REQ-034: Empty buffer, reset released, push res_in=15'd35 -> next cycle word_out=16'h0046, word_valid=1, count=1.
REQ-035: Push 15'd153 then 15'h7F66 (-153) with word_ready=1 -> outputs 16'h0133 then 16'hFECC in order.
REQ-036: Push 15'h7FFF, then 15'h0000 -> word_out 16'hFFFE then 16'h0001, and neg_zero_seen=1 from the cycle after the first push.
REQ-037: word_ready=0, res_valid=1 for 6 cycles with values 1..6 -> res_ready=0 after the 4th push, count=4, then draining yields 1..4 only, each with correct parity.
REQ-038: With count=2, assert push and pop on the same edge for 10 cycles -> count stays 2, and output order matches input order through pointer wrap.
REQ-039: With count=3 and neg_zero_seen=1, assert reset for one cycle with res_valid=1 -> count=0, word_valid=0, res_ready=1, neg_zero_seen=0, and no word accepted.
